// File: rtl/mux4_arb_pkg.sv
// Shared types and the round-robin pick helper for the 4:1 mux select arbiter.
// Picker scans ptr+1, ptr+2, ... mod NUM_SRC.
package mux4_arb_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Highest offset first so the nearest requester after ptr wins.
    function automatic pick_t rr_pick(
        input logic [NUM_SRC-1:0] req,
        input logic [SEL_W-1:0]   ptr
    );
        pick_t            res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational rotate-and-priority-encode picker for four requesters.
// Returns the first set request after ptr, wrapping to ptr itself last.
module mux4_rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    pick_t pk;

    assign pk    = rr_pick(req, ptr);
    assign idx   = pk.idx;
    assign found = pk.found;

endmodule

// File: rtl/mux4_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux with minimum grant dwell.
// Optional MUX4_ARB_LOCK_EN adds a lock input that extends a grant past expiry.
module mux4_sel_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
`ifdef MUX4_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] grant,
    output logic               sel_valid,
    output logic               switch_pulse
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SEL_W-1:0]   last_ptr, last_n;
    logic [SEL_W-1:0]   sel_n;
    logic [NUM_SRC-1:0] grant_n;
    logic               valid_n;
    logic               pulse_n;
    logic               do_grant;
    logic               hold_ok;
    logic [SEL_W-1:0]   pk_idx;
    logic               pk_found;

    // In HOLD last_ptr equals sel, so one picker serves every arbitration.
    mux4_rr_pick u_pick (
        .req   (req),
        .ptr   (last_ptr),
        .idx   (pk_idx),
        .found (pk_found)
    );

`ifdef MUX4_ARB_LOCK_EN
    assign hold_ok = lock;
`else
    assign hold_ok = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_n   = last_ptr;
        sel_n    = sel;
        grant_n  = grant;
        valid_n  = sel_valid;
        pulse_n  = 1'b0;
        do_grant = 1'b0;
        unique case (state)
            IDLE: begin
                do_grant = pk_found;
            end
            HOLD: begin
                if (!req[sel]) begin
                    if (pk_found) begin
                        do_grant = 1'b1;
                    end else begin
                        state_n = IDLE;
                        sel_n   = '0;
                        grant_n = '0;
                        valid_n = 1'b0;
                    end
                end else if (cnt == '0) begin
                    do_grant = !hold_ok;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
        endcase
        if (do_grant) begin
            state_n = HOLD;
            cnt_n   = CNT_W'(HOLD_CYCLES - 1);
            last_n  = pk_idx;
            sel_n   = pk_idx;
            grant_n = NUM_SRC'(1) << pk_idx;
            valid_n = 1'b1;
            pulse_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            last_ptr     <= SEL_W'(NUM_SRC - 1);
            sel          <= '0;
            grant        <= '0;
            sel_valid    <= 1'b0;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            last_ptr     <= last_n;
            sel          <= sel_n;
            grant        <= grant_n;
            sel_valid    <= valid_n;
            switch_pulse <= pulse_n;
        end
    end

endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Scoreboard bench for mux4_sel_arbiter against an age-counting reference model.
// Directed scenarios followed by randomized request traffic.
module tb_mux4_sel_arbiter;

    localparam int HOLD = 4;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
        logic       pulse;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       lock = 1'b0;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       sel_valid;
    logic       switch_pulse;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mux4_sel_arbiter #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
`ifdef MUX4_ARB_LOCK_EN
        .lock         (lock),
`endif
        .sel          (sel),
        .grant        (grant),
        .sel_valid    (sel_valid),
        .switch_pulse (switch_pulse)
    );

    // First requester strictly after 'from', wrapping; -1 if none.
    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    // Reference model: cur = granted source (-1 idle), age = cycles visible.
    initial begin : model
        int   cur;
        int   age;
        int   last;
        int   nxt;
        bit   pulse;
        exp_t e;
        cur  = -1;
        age  = 0;
        last = 3;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cur  = -1;
                age  = 0;
                last = 3;
                exp_q.delete();
            end else begin
                pulse = 1'b0;
                nxt   = -2;
                if (cur < 0) begin
                    nxt = pick(req, last);
                end else if (!req[cur]) begin
                    nxt = pick(req, cur);
                    if (nxt < 0) cur = -1;
                end else if (age >= HOLD) begin
                    nxt = pick(req, cur);
                end else begin
                    age++;
                end
                if (nxt >= 0) begin
                    cur   = nxt;
                    last  = nxt;
                    age   = 1;
                    pulse = 1'b1;
                end
                e.valid = (cur >= 0);
                e.sel   = (cur >= 0) ? 2'(cur) : 2'b00;
                e.grant = (cur >= 0) ? (4'b0001 << cur) : 4'b0000;
                e.pulse = pulse;
                exp_q.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty t=%0t no expected entry", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (sel !== e.sel || grant !== e.grant ||
                        sel_valid !== e.valid || switch_pulse !== e.pulse) begin
                        errors++;
                        $display("FAIL outputs t=%0t req=%b got sel=%b grant=%b v=%b p=%b exp sel=%b grant=%b v=%b p=%b",
                                 $time, req, sel, grant, sel_valid, switch_pulse,
                                 e.sel, e.grant, e.valid, e.pulse);
                    end
                end
            end
        end
    end

    task automatic step(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = r;
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (sel !== 2'b00 || grant !== 4'b0000 ||
            sel_valid !== 1'b0 || switch_pulse !== 1'b0) begin
            errors++;
            $display("FAIL %s got sel=%b grant=%b v=%b p=%b exp all zero",
                     name, sel, grant, sel_valid, switch_pulse);
        end
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;
        req   = 4'b1111;
        step(4'b1111, 20);
        step(4'b0100, 12);
        step(4'b0000, 2);
        step(4'b0010, 2);
        step(4'b1000, 6);
        step(4'b0010, 2);
        step(4'b0000, 3);
        step(4'b0100, 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0110;
        step(4'b0110, 6);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
        end
        step(4'b0000, 3);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
